// File: rtl/slice_column_scheduler.sv
// ---------------------------------------------------------------------------
// slice_column_scheduler
//
// Frame-level sequencer for the raycast renderer. On an accepted frame_start
// it latches the player pose, then walks column_count over every screen
// column. For each column it:
//   1. pulses begin_calc to the slice engine,
//   2. waits for end_calc,
//   3. clamps slice_size to MAX_HEIGHT,
//   4. presents (column, height) to the column drawer over valid/ready.
// After the last column it pulses frame_done for one cycle and returns to
// idle.
//
// Optional feature (compile-time macro SLICE_TIMEOUT_EN):
//   A per-column wait limit of TIMEOUT_CYCLES. When the engine does not
//   answer in time, the column is presented with height 0 and the sticky
//   timeout_err flag is set. Without the macro the scheduler waits forever
//   and timeout_err is tied low.
//
// Ports:
//   clock, reset               system clock, asynchronous active-high reset
//   frame_start                one-cycle frame request (accepted only when idle)
//   playerX/Y, angle_X/Y       pose, sampled on an accepted frame_start
//   calc_playerX/Y, calc_angle_X/Y
//                              latched pose to the slice engine
//   column_count               current column to the slice engine
//   begin_calc / end_calc      engine start pulse / engine done
//   slice_size                 engine result, valid while end_calc is high
//   slice_valid / slice_ready  drawer handshake
//   slice_column/slice_height  presented result (height clamped)
//   frame_busy, frame_done     frame in progress / end-of-frame pulse
//   timeout_err                sticky per-frame engine timeout flag
// ---------------------------------------------------------------------------
module slice_column_scheduler #(
  parameter int NUM_COLUMNS    = 160,
  parameter int MAX_HEIGHT     = 120,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_start,
  input  logic [12:0] playerX,
  input  logic [12:0] playerY,
  input  logic [9:0]  angle_X,
  input  logic [9:0]  angle_Y,
  output logic [12:0] calc_playerX,
  output logic [12:0] calc_playerY,
  output logic [9:0]  calc_angle_X,
  output logic [9:0]  calc_angle_Y,
  output logic [7:0]  column_count,
  output logic        begin_calc,
  input  logic        end_calc,
  input  logic [6:0]  slice_size,
  output logic        slice_valid,
  input  logic        slice_ready,
  output logic [7:0]  slice_column,
  output logic [6:0]  slice_height,
  output logic        frame_busy,
  output logic        frame_done,
  output logic        timeout_err
);

  // Reject parameter values the fixed port widths cannot represent.
  if (MAX_HEIGHT < 0 || MAX_HEIGHT > 127) begin : g_bad_max_height
    $error("MAX_HEIGHT must fit in the 7-bit slice_height port");
  end
  if (NUM_COLUMNS < 1 || NUM_COLUMNS > 256) begin : g_bad_num_columns
    $error("NUM_COLUMNS must fit in the 8-bit column_count port");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must fit in the 8-bit wait counter");
  end

  localparam logic [6:0] HEIGHT_CAP = 7'(MAX_HEIGHT);
  localparam logic [7:0] LAST_COL   = 8'(NUM_COLUMNS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_CALC,
    S_PRESENT,
    S_NEXT,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [12:0] px;
    logic [12:0] py;
    logic [9:0]  ax;
    logic [9:0]  ay;
  } pose_t;

  state_t     state_q, state_d;
  pose_t      pose_q, pose_d;
  logic [7:0] col_q, col_d;
  logic [7:0] scol_q, scol_d;
  logic [6:0] height_q, height_d;
  logic       timeout_hit;

  // NOTE: every combinational output gets a default before the case
  // statement so that no path leaves a variable unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    pose_d   = pose_q;
    col_d    = col_q;
    scol_d   = scol_q;
    height_d = height_q;
    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          pose_d  = '{px: playerX, py: playerY, ax: angle_X, ay: angle_Y};
          col_d   = 8'd0;
          state_d = S_START;
        end
      end
      S_START: state_d = S_WAIT_CALC;
      S_WAIT_CALC: begin
        if (end_calc) begin
          height_d = (slice_size > HEIGHT_CAP) ? HEIGHT_CAP : slice_size;
          scol_d   = col_q;
          state_d  = S_PRESENT;
        end else if (timeout_hit) begin
          height_d = 7'd0;
          scol_d   = col_q;
          state_d  = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (slice_ready) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (col_q == LAST_COL) begin
          state_d = S_DONE;
        end else begin
          col_d   = col_q + 8'd1;
          state_d = S_START;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled before the edge. The async reset
  // clears every register, so all outputs read 0 immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pose_q   <= '0;
      col_q    <= 8'd0;
      scol_q   <= 8'd0;
      height_q <= 7'd0;
    end else begin
      state_q  <= state_d;
      pose_q   <= pose_d;
      col_q    <= col_d;
      scol_q   <= scol_d;
      height_q <= height_d;
    end
  end

`ifdef SLICE_TIMEOUT_EN
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       timeout_err_q, timeout_err_d;
  logic       frame_accept;

  assign frame_accept = (state_q == S_IDLE) && frame_start;
  // The counter holds (cycles spent in WAIT_CALC - 1), so the limit fires on
  // the TIMEOUT_CYCLES-th wait cycle. end_calc on that cycle still wins.
  assign timeout_hit  = (state_q == S_WAIT_CALC) && !end_calc &&
                        (wait_cnt_q == 8'(TIMEOUT_CYCLES - 1));

  always_comb begin
    // Held at zero outside WAIT_CALC, which clears it on every entry.
    wait_cnt_d    = (state_q == S_WAIT_CALC) ? wait_cnt_q + 8'd1 : 8'd0;
    timeout_err_d = timeout_err_q;
    if (frame_accept)     timeout_err_d = 1'b0;
    else if (timeout_hit) timeout_err_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt_q    <= 8'd0;
      timeout_err_q <= 1'b0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign calc_playerX = pose_q.px;
  assign calc_playerY = pose_q.py;
  assign calc_angle_X = pose_q.ax;
  assign calc_angle_Y = pose_q.ay;
  assign column_count = col_q;
  assign slice_column = scol_q;
  assign slice_height = height_q;
  assign begin_calc   = (state_q == S_START);
  assign slice_valid  = (state_q == S_PRESENT);
  assign frame_done   = (state_q == S_DONE);
  assign frame_busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_slice_column_scheduler.sv
// ---------------------------------------------------------------------------
// tb_slice_column_scheduler
//
// Randomized bench with a behavioural slice-engine model, a drawer model with
// scripted back-pressure, and a scoreboard queue of expected (column, height)
// results. Frame timing is predicted from per-column latencies and stalls.
// ---------------------------------------------------------------------------
module tb_slice_column_scheduler;
  localparam int NC = 160;
  localparam int MH = 120;
  localparam int TO = 255;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        frame_start = 1'b0;
  logic [12:0] playerX = '0, playerY = '0;
  logic [9:0]  angle_X = '0, angle_Y = '0;
  logic [12:0] calc_playerX, calc_playerY;
  logic [9:0]  calc_angle_X, calc_angle_Y;
  logic [7:0]  column_count;
  logic        begin_calc;
  logic        end_calc = 1'b0;
  logic [6:0]  slice_size = '0;
  logic        slice_valid;
  logic        slice_ready = 1'b0;
  logic [7:0]  slice_column;
  logic [6:0]  slice_height;
  logic        frame_busy, frame_done, timeout_err;

  slice_column_scheduler #(.NUM_COLUMNS(NC), .MAX_HEIGHT(MH), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .frame_start(frame_start),
    .playerX(playerX), .playerY(playerY), .angle_X(angle_X), .angle_Y(angle_Y),
    .calc_playerX(calc_playerX), .calc_playerY(calc_playerY),
    .calc_angle_X(calc_angle_X), .calc_angle_Y(calc_angle_Y),
    .column_count(column_count), .begin_calc(begin_calc), .end_calc(end_calc),
    .slice_size(slice_size), .slice_valid(slice_valid), .slice_ready(slice_ready),
    .slice_column(slice_column), .slice_height(slice_height),
    .frame_busy(frame_busy), .frame_done(frame_done), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int col;
    int height;
  } result_t;

  result_t     exp_q[$];
  int          sizes[NC];
  int          lat[NC];    // engine answer latency in wait cycles, 0 = never
  int          stall[NC];  // drawer holds ready low this many valid cycles
  logic [45:0] pose_exp;
  int          total = 0;
  int          bad = 0;
  int          eng_col = 0, eng_cnt = 0, eng_ans = 0;
  bit          spur_en = 1'b0;
  int          mon_col = 0, st_left = 0;
  bit          loaded = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_column_count"}, column_count, 0);
    check({tag, "_slice_height"}, slice_height, 0);
    check({tag, "_slice_column"}, slice_column, 0);
    check({tag, "_begin_calc"},   begin_calc,   0);
    check({tag, "_slice_valid"},  slice_valid,  0);
    check({tag, "_frame_busy"},   frame_busy,   0);
    check({tag, "_frame_done"},   frame_done,   0);
    check({tag, "_timeout_err"},  timeout_err,  0);
    check({tag, "_pose"}, {calc_playerX, calc_playerY, calc_angle_X, calc_angle_Y}, 0);
  endtask

  // Slice engine model: numbers columns by counting begin_calc pulses.
  initial forever begin
    @(negedge clock);
    if (reset) begin
      end_calc = 1'b0;
      eng_cnt  = 0;
    end else begin
      end_calc   = 1'b0;
      slice_size = 7'($urandom);
      if (begin_calc) begin
        check("column_count", column_count, eng_col);
        check("pose_latch", {calc_playerX, calc_playerY, calc_angle_X, calc_angle_Y}, pose_exp);
        eng_ans = eng_col;
        eng_cnt = (eng_col < NC) ? lat[eng_col] : 0;
        eng_col++;
      end else if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          end_calc   = 1'b1;
          slice_size = 7'(sizes[eng_ans]);
        end
      end else if (spur_en && slice_valid) begin
        end_calc   = 1'b1;   // stray answer while presenting
        slice_size = 7'h7f;
      end
    end
  end

  // Drawer model and scoreboard monitor.
  initial forever begin
    @(negedge clock);
    if (reset) begin
      slice_ready = 1'b0;
    end else if (slice_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", slice_valid, 0);
        slice_ready = 1'b1;
      end else begin
        check("slice_column", slice_column, exp_q[0].col);
        check("slice_height", slice_height, exp_q[0].height);
        if (!loaded) begin
          st_left = (mon_col < NC) ? stall[mon_col] : 0;
          loaded  = 1'b1;
        end
        if (st_left > 0) begin
          slice_ready = 1'b0;
          st_left--;
        end else begin
          slice_ready = 1'b1;
          void'(exp_q.pop_front());
          mon_col++;
          loaded = 1'b0;
        end
      end
    end else begin
      slice_ready = 1'($urandom);
    end
  end

  function automatic int frame_cycles();
    int t = 1;
    for (int c = 0; c < NC; c++) t += 3 + ((lat[c] == 0) ? TO : lat[c]) + stall[c];
    return t;
  endfunction

  task automatic randomize_frame();
    for (int c = 0; c < NC; c++) begin
      sizes[c] = $urandom_range(0, 127);
      lat[c]   = $urandom_range(1, 4);
      stall[c] = $urandom_range(0, 2);
    end
  endtask

  task automatic start_frame();
    logic [12:0] px = 13'($urandom);
    logic [12:0] py = 13'($urandom);
    logic [9:0]  ax = 10'($urandom);
    logic [9:0]  ay = 10'($urandom);
    pose_exp = {px, py, ax, ay};
    for (int c = 0; c < NC; c++)
      exp_q.push_back('{c, (lat[c] == 0) ? 0 : ((sizes[c] > MH) ? MH : sizes[c])});
    eng_col = 0;
    mon_col = 0;
    loaded  = 1'b0;
    @(posedge clock); #1;
    frame_start = 1'b1;
    playerX = px; playerY = py; angle_X = ax; angle_Y = ay;
    @(posedge clock); #1;
    frame_start = 1'b0;
    playerX = 13'($urandom); angle_Y = 10'($urandom);  // latches must hold
    @(negedge clock);
    check("first_begin_calc", begin_calc, 1);
    check("first_frame_busy", frame_busy, 1);
    check("timeout_err_cleared", timeout_err, 0);
  endtask

  task automatic finish_frame(input int exp_cycles, input bit inject);
    int cyc = 1;
    bit done = 1'b0;
    while (!done && cyc < exp_cycles + 100) begin
      @(negedge clock);
      cyc++;
      if (inject && cyc == 50) begin
        frame_start = 1'b1;
        playerX = 13'($urandom);
      end
      if (inject && cyc == 51) frame_start = 1'b0;
      if (frame_done) done = 1'b1;
    end
    check("frame_done_seen", done, 1);
    check("frame_cycles", cyc, exp_cycles);
    check("done_without_valid", slice_valid, 0);
    check("done_busy", frame_busy, 1);
    check("results_all_seen", exp_q.size(), 0);
    @(negedge clock);
    check("done_one_pulse", frame_done, 0);
    check("idle_not_busy", frame_busy, 0);
  endtask

  task automatic do_reset(input string tag);
    #2 reset = 1'b1;
    #1 check_zero(tag);
    exp_q.delete();
    eng_col = 0; mon_col = 0; loaded = 1'b0; st_left = 0;
    spur_en = 1'b0; frame_start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: summary not reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    do_reset("reset_initial");

    // Full frame, engine echoes column mod 128 after 3 wait cycles.
    for (int c = 0; c < NC; c++) begin
      sizes[c] = c % 128; lat[c] = 3; stall[c] = 0;
    end
    start_frame();
    finish_frame(NC * 6 + 1, 1'b0);

    // Random results and latencies, 5-cycle stall on column 10, stray
    // end_calc while presenting, frame_start and pose change mid-frame.
    randomize_frame();
    stall[10] = 5;
    spur_en = 1'b1;
    start_frame();
    finish_frame(frame_cycles(), 1'b1);
    spur_en = 1'b0;

    // Reset while waiting on column 37, then a clean frame from column 0.
    randomize_frame();
    lat[37] = 0;
    start_frame();
    n = 0;
    while (eng_col < 38 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    repeat (5) @(negedge clock);
    check("abort_column", column_count, 37);
    do_reset("reset_mid_frame");
    randomize_frame();
    start_frame();
    finish_frame(frame_cycles(), 1'b0);

    // Engine never answers column 5.
    randomize_frame();
    lat[5] = 0;
    start_frame();
`ifdef SLICE_TIMEOUT_EN
    finish_frame(frame_cycles(), 1'b0);
    check("timeout_err_set", timeout_err, 1);
`else
    n = 0;
    while (eng_col < 6 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    repeat (300) @(negedge clock);
    check("hang_column", column_count, 5);
    check("hang_no_valid", slice_valid, 0);
    check("hang_no_begin", begin_calc, 0);
    check("hang_busy", frame_busy, 1);
    check("hang_no_timeout_err", timeout_err, 0);
    do_reset("reset_after_hang");
`endif
    randomize_frame();
    start_frame();
    finish_frame(frame_cycles(), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
